// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces two coin sensors, queues
// accepted coins and replays them to the vending machine as spaced one-cycle codes.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    input  logic       enable,
    output logic [1:0] in_code,
    output logic       reject,
    output logic [3:0] fifo_count
);
    localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] DEPTH   = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    // Bit 0 is the 5 line, bit 1 the 10 line, so a single event equals its coin code.
    logic [1:0] raw_vec;
    logic [1:0] event_vec;
    assign raw_vec = {coin10_raw, coin5_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : line_g
            logic       sync1_q, sync1_d;
            logic       sync2_q, sync2_d;
            logic       deb_q, deb_d;
            logic       event_q, event_d;
            logic [3:0] cnt_q, cnt_d;

            always_comb begin
                sync1_d = raw_vec[gi];
                sync2_d = sync1_q;
                deb_d   = deb_q;
                cnt_d   = 4'd0;
                if (sync2_q != deb_q) begin
                    if (cnt_q == DB_LAST) begin
                        deb_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                event_d = deb_d & ~deb_q;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    deb_q   <= 1'b0;
                    cnt_q   <= 4'd0;
                    event_q <= 1'b0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    deb_q   <= deb_d;
                    cnt_q   <= cnt_d;
                    event_q <= event_d;
                end
            end

            assign event_vec[gi] = event_q;
        end
    endgenerate

    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;
    logic [1:0]       in_code_q, in_code_d;
    logic [1:0]       push_code;
    logic             reject_q, reject_d;
    logic             push, pop;
    state_t           state_q, state_d;

    // A pop in this cycle frees a slot, so a full FIFO can still take the new coin.
    always_comb begin
        pop       = (state_q == IDLE) && (count_q != 4'd0);
        push      = 1'b0;
        push_code = 2'b00;
        reject_d  = 1'b0;
        if (event_vec == 2'b11) begin
            reject_d = 1'b1;
        end else if (event_vec != 2'b00) begin
            if (!enable || ((count_q == DEPTH) && !pop)) begin
                reject_d = 1'b1;
            end else begin
                push      = 1'b1;
                push_code = event_vec;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        in_code_d = 2'b00;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = EMIT;
                    in_code_d = mem[rd_ptr_q];
                end
            end
            EMIT:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Storage carries no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_code;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 4'd0;
            in_code_q <= 2'b00;
            reject_q  <= 1'b0;
            state_q   <= IDLE;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            in_code_q <= in_code_d;
            reject_q  <= reject_d;
            state_q   <= state_d;
        end
    end

    assign in_code    = in_code_q;
    assign reject     = reject_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a default instance (debounce 4) for timing and
// filtering, and a fast-debounce instance (debounce 2) to build up a queue.
module tb_coin_acceptor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, c5_a, c10_a, en_a;
    logic [1:0] code_a;
    logic       rej_a;
    logic [3:0] cnt_a;
    logic       rst_b, c5_b, c10_b, en_b;
    logic [1:0] code_b;
    logic       rej_b;
    logic [3:0] cnt_b;

    coin_acceptor #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst_a), .coin5_raw(c5_a), .coin10_raw(c10_a), .enable(en_a),
        .in_code(code_a), .reject(rej_a), .fifo_count(cnt_a)
    );

    coin_acceptor #(.DEBOUNCE_CYCLES(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst_b), .coin5_raw(c5_b), .coin10_raw(c10_b), .enable(en_b),
        .in_code(code_b), .reject(rej_b), .fifo_count(cnt_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [1:0] codes_a [$];
    logic [1:0] codes_b [$];
    int         times_b [$];
    int         rej_a_total = 0;
    int         rej_b_total = 0;

    // Transaction log: one line per emitted code or reject pulse.
    always @(negedge clk) begin
        if (code_a != 2'b00) begin
            codes_a.push_back(code_a);
            $display("[TB] dut_a in_code=%b cycle %0d", code_a, cyc);
        end
        if (rej_a) begin
            rej_a_total++;
            $display("[TB] dut_a reject cycle %0d", cyc);
        end
        if (code_b != 2'b00) begin
            codes_b.push_back(code_b);
            times_b.push_back(cyc);
            $display("[TB] dut_b in_code=%b cycle %0d", code_b, cyc);
        end
        if (rej_b) begin
            rej_b_total++;
            $display("[TB] dut_b reject cycle %0d", cyc);
        end
        cyc++;
    end

    task automatic drive_a10(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            c10_a = v;
        end
    endtask

    // Alternating 2-cycle slots on the two lines: one coin event every 2 cycles.
    task automatic drive_slots_b(input int nslots);
        for (int j = 0; j < nslots; j++) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                c5_b  = (j % 2 == 0);
                c10_b = (j % 2 == 1);
            end
        end
        @(negedge clk);
        c5_b  = 1'b0;
        c10_b = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (code_a !== 2'b00) begin fails++; $display("FAIL reset in_code_a got %b want 00", code_a); end
        tests++; if (rej_a !== 1'b0) begin fails++; $display("FAIL reset reject_a got %b want 0", rej_a); end
        tests++; if (cnt_a !== 4'd0) begin fails++; $display("FAIL reset fifo_count_a got %0d want 0", cnt_a); end
        tests++; if (code_b !== 2'b00) begin fails++; $display("FAIL reset in_code_b got %b want 00", code_b); end
        tests++; if (cnt_b !== 4'd0) begin fails++; $display("FAIL reset fifo_count_b got %0d want 0", cnt_b); end
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_clean_coin();
        logic [1:0] exp_code;
        int r0;
        r0 = rej_a_total;
        @(negedge clk);
        c5_a = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 10) c5_a = 1'b0;
            exp_code = (n == 8) ? 2'b01 : 2'b00;
            tests++;
            if (code_a !== exp_code) begin
                fails++; $display("FAIL clean_coin in_code after edge %0d got %b want %b", n, code_a, exp_code);
            end
            if (n == 7) begin
                tests++; if (cnt_a !== 4'd1) begin fails++; $display("FAIL clean_coin fifo_count after edge 7 got %0d want 1", cnt_a); end
            end
            if (n == 8) begin
                tests++; if (cnt_a !== 4'd0) begin fails++; $display("FAIL clean_coin fifo_count after edge 8 got %0d want 0", cnt_a); end
            end
        end
        @(negedge clk);
        tests++; if (rej_a_total - r0 !== 0) begin fails++; $display("FAIL clean_coin rejects got %0d want 0", rej_a_total - r0); end
    endtask

    task automatic test_glitch();
        int q0, r0;
        q0 = codes_a.size();
        r0 = rej_a_total;
        drive_a10(1'b1, 3);
        drive_a10(1'b0, 6);
        drive_a10(1'b1, 1);
        drive_a10(1'b0, 1);
        drive_a10(1'b1, 8);
        drive_a10(1'b0, 1);
        repeat (20) @(negedge clk);
        tests++;
        if (codes_a.size() - q0 !== 1) begin
            fails++; $display("FAIL glitch pulse count got %0d want 1", codes_a.size() - q0);
        end else begin
            tests++; if (codes_a[q0] !== 2'b10) begin fails++; $display("FAIL glitch code got %b want 10", codes_a[q0]); end
        end
        tests++; if (rej_a_total - r0 !== 0) begin fails++; $display("FAIL glitch rejects got %0d want 0", rej_a_total - r0); end
    endtask

    task automatic test_simultaneous();
        int q0, r0, max_cnt;
        q0 = codes_a.size();
        r0 = rej_a_total;
        max_cnt = 0;
        @(negedge clk);
        c5_a = 1'b1;
        c10_a = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            if (n == 8) begin
                c5_a = 1'b0;
                c10_a = 1'b0;
            end
            if (int'(cnt_a) > max_cnt) max_cnt = int'(cnt_a);
        end
        tests++; if (rej_a_total - r0 !== 1) begin fails++; $display("FAIL simultaneous rejects got %0d want 1", rej_a_total - r0); end
        tests++; if (codes_a.size() - q0 !== 0) begin fails++; $display("FAIL simultaneous pulses got %0d want 0", codes_a.size() - q0); end
        tests++; if (max_cnt !== 0) begin fails++; $display("FAIL simultaneous max fifo_count got %0d want 0", max_cnt); end
    endtask

    task automatic test_held_through_reset();
        logic [1:0] exp_code;
        int r0;
        @(negedge clk);
        rst_a = 1'b0;
        c5_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        r0 = rej_a_total;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 12) c5_a = 1'b0;
            exp_code = (n == 8) ? 2'b01 : 2'b00;
            tests++;
            if (code_a !== exp_code) begin
                fails++; $display("FAIL held_reset in_code after edge %0d got %b want %b", n, code_a, exp_code);
            end
        end
        repeat (10) @(negedge clk);
        tests++; if (rej_a_total - r0 !== 0) begin fails++; $display("FAIL held_reset rejects got %0d want 0", rej_a_total - r0); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp [14];
        int q0, r0, n;
        exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01,
                2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        q0 = codes_b.size();
        r0 = rej_b_total;
        drive_slots_b(16);
        repeat (60) @(negedge clk);
        n = codes_b.size() - q0;
        tests++; if (rej_b_total - r0 !== 2) begin fails++; $display("FAIL back_to_back rejects got %0d want 2", rej_b_total - r0); end
        tests++;
        if (n !== 14) begin
            fails++; $display("FAIL back_to_back pulse count got %0d want 14", n);
        end else begin
            for (int i = 0; i < 14; i++) begin
                tests++;
                if (codes_b[q0 + i] !== exp[i]) begin
                    fails++; $display("FAIL back_to_back order pulse %0d got %b want %b", i, codes_b[q0 + i], exp[i]);
                end
            end
            for (int i = 1; i < 14; i++) begin
                tests++;
                if (times_b[q0 + i] - times_b[q0 + i - 1] !== 3) begin
                    fails++; $display("FAIL back_to_back spacing pulse %0d got %0d want 3", i, times_b[q0 + i] - times_b[q0 + i - 1]);
                end
            end
        end
        tests++; if (cnt_b !== 4'd0) begin fails++; $display("FAIL back_to_back final fifo_count got %0d want 0", cnt_b); end
    endtask

    task automatic test_enable_drain();
        logic [1:0] exp [5];
        int q0, r0;
        exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        q0 = codes_b.size();
        r0 = rej_b_total;
        drive_slots_b(5);
        repeat (3) @(negedge clk);
        tests++; if (cnt_b !== 4'd2) begin fails++; $display("FAIL enable_drain queued got %0d want 2", cnt_b); end
        en_b = 1'b0;
        c5_b = 1'b1;
        repeat (3) @(negedge clk);
        c5_b = 1'b0;
        repeat (25) @(negedge clk);
        tests++; if (rej_b_total - r0 !== 1) begin fails++; $display("FAIL enable_drain rejects got %0d want 1", rej_b_total - r0); end
        tests++;
        if (codes_b.size() - q0 !== 5) begin
            fails++; $display("FAIL enable_drain pulse count got %0d want 5", codes_b.size() - q0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (codes_b[q0 + i] !== exp[i]) begin
                    fails++; $display("FAIL enable_drain order pulse %0d got %b want %b", i, codes_b[q0 + i], exp[i]);
                end
            end
        end
        tests++; if (cnt_b !== 4'd0) begin fails++; $display("FAIL enable_drain final fifo_count got %0d want 0", cnt_b); end
        en_b = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int q0, r0;
        drive_slots_b(10);
        @(negedge clk);
        tests++; if (code_b !== 2'b10) begin fails++; $display("FAIL reset_mid in_code before reset got %b want 10", code_b); end
        tests++; if (cnt_b !== 4'd3) begin fails++; $display("FAIL reset_mid fifo_count before reset got %0d want 3", cnt_b); end
        rst_b = 1'b0;
        #1;
        tests++; if (code_b !== 2'b00) begin fails++; $display("FAIL reset_mid in_code in reset got %b want 00", code_b); end
        tests++; if (cnt_b !== 4'd0) begin fails++; $display("FAIL reset_mid fifo_count in reset got %0d want 0", cnt_b); end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        q0 = codes_b.size();
        r0 = rej_b_total;
        repeat (20) @(negedge clk);
        tests++; if (codes_b.size() - q0 !== 0) begin fails++; $display("FAIL reset_mid pulses after release got %0d want 0", codes_b.size() - q0); end
        tests++; if (rej_b_total - r0 !== 0) begin fails++; $display("FAIL reset_mid rejects after release got %0d want 0", rej_b_total - r0); end
        tests++; if (cnt_b !== 4'd0) begin fails++; $display("FAIL reset_mid fifo_count after release got %0d want 0", cnt_b); end
        @(negedge clk);
        c5_b = 1'b1;
        repeat (2) @(negedge clk);
        c5_b = 1'b0;
        repeat (12) @(negedge clk);
        tests++;
        if (codes_b.size() - q0 !== 1) begin
            fails++; $display("FAIL reset_mid new coin pulses got %0d want 1", codes_b.size() - q0);
        end else begin
            tests++; if (codes_b[q0] !== 2'b01) begin fails++; $display("FAIL reset_mid new coin code got %b want 01", codes_b[q0]); end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        c5_a = 1'b0; c10_a = 1'b0; en_a = 1'b1;
        c5_b = 1'b0; c10_b = 1'b0; en_b = 1'b1;
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        test_reset();
        test_clean_coin();
        test_glitch();
        test_simultaneous();
        test_held_through_reset();
        test_back_to_back();
        test_enable_drain();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
